// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF read port, DM read/write port and the shared memory port.
// Signal names keep the arbiter's view (i_ = into the arbiter, o_ = out of it).
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic              i_if_req;
  logic [AW-1:0]     i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DW-1:0]     o_if_rdata;

  logic              i_dm_req;
  logic              i_dm_we;
  logic [AW-1:0]     i_dm_addr;
  logic [DW-1:0]     i_dm_wdata;
  logic [DW/8-1:0]   i_dm_sel;
  logic              o_dm_gnt;
  logic              o_dm_rvalid;
  logic [DW-1:0]     o_dm_rdata;

  logic              o_mem_ce;
  logic              o_mem_we;
  logic [AW-1:0]     o_mem_addr;
  logic [DW-1:0]     o_mem_wdata;
  logic [DW/8-1:0]   o_mem_sel;
  logic [DW-1:0]     i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_sel, i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_sel, i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between an IF read port and a DM port.
// DM has priority; a starvation counter forces an IF win after STARVE_LIM consecutive losses.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SCW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CW-1:0]  CntLoad   = CW'(MEM_LAT - 1);
  localparam logic [SCW-1:0] StarveMax = SCW'(STARVE_LIM);
  localparam logic           StarveOn  = (STARVE_LIM > 0);

  typedef enum logic {StFree, StBusy} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_owner_dm, w_owner_dm_d;
  logic            r_we, w_we_d;
  logic [SCW-1:0]  r_starve, w_starve_d;

  logic w_arb, w_resp, w_if_force, w_dm_win, w_if_win;

  // Arbitration is open when idle or on the response cycle, giving back-to-back grants.
  assign w_arb      = (r_state == StFree) || (r_cnt == '0);
  assign w_resp     = (r_state == StBusy) && (r_cnt == '0);
  assign w_if_force = StarveOn && bus.i_if_req && (r_starve >= StarveMax);
  assign w_dm_win   = w_arb && bus.i_dm_req && !w_if_force;
  assign w_if_win   = w_arb && bus.i_if_req && !w_dm_win;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_owner_dm_d = r_owner_dm;
    w_we_d       = r_we;
    w_starve_d   = r_starve;

    if (w_dm_win || w_if_win) begin
      w_state_d    = StBusy;
      w_cnt_d      = CntLoad;
      w_owner_dm_d = w_dm_win;
      w_we_d       = w_dm_win && bus.i_dm_we;
    end else if (r_state == StBusy) begin
      if (r_cnt == '0) begin
        w_state_d = StFree;
      end else begin
        w_cnt_d = r_cnt - CW'(1);
      end
    end

    if (!bus.i_if_req || w_if_win) begin
      w_starve_d = '0;
    end else if (w_dm_win && (r_starve < StarveMax)) begin
      w_starve_d = r_starve + SCW'(1);
    end
  end

  always_comb begin
    bus.o_if_gnt    = 1'b0;
    bus.o_if_rvalid = 1'b0;
    bus.o_if_rdata  = '0;
    bus.o_dm_gnt    = 1'b0;
    bus.o_dm_rvalid = 1'b0;
    bus.o_dm_rdata  = '0;
    bus.o_mem_ce    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_sel   = '0;

    if (!i_rst) begin
      if (w_resp) begin
        if (r_owner_dm) begin
          bus.o_dm_rvalid = 1'b1;
          bus.o_dm_rdata  = r_we ? '0 : bus.i_mem_rdata;
        end else begin
          bus.o_if_rvalid = 1'b1;
          bus.o_if_rdata  = bus.i_mem_rdata;
        end
      end

      if (w_dm_win) begin
        bus.o_dm_gnt    = 1'b1;
        bus.o_mem_ce    = 1'b1;
        bus.o_mem_we    = bus.i_dm_we;
        bus.o_mem_addr  = bus.i_dm_addr;
        bus.o_mem_wdata = bus.i_dm_wdata;
        bus.o_mem_sel   = bus.i_dm_sel;
      end else if (w_if_win) begin
        bus.o_if_gnt    = 1'b1;
        bus.o_mem_ce    = 1'b1;
        bus.o_mem_addr  = bus.i_if_addr;
        bus.o_mem_sel   = '1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StFree;
      r_cnt      <= '0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_owner_dm <= w_owner_dm_d;
      r_we       <= w_we_d;
      r_starve   <= w_starve_d;
    end
  end
endmodule
